// File: rtl/memory_slice_bank.sv
`default_nettype none
// ============================================================================
// memory_slice_bank : sliced simple dual-port RAM with a rotating
//                     logical-to-physical slice map and sticky range error.
// Revision : 1.0
// ============================================================================
module memory_slice_bank #(
   parameter int DW    = 24,
   parameter int DEPTH = 40,
   parameter int NSLC  = 3,
   parameter int AW    = 6,
   parameter int SW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   input  logic [SW-1:0] rd_slc,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [SW-1:0] wr_slc,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ack,
   input  logic          rotate,
   output logic [SW-1:0] base,
   output logic          err_oob,
   input  logic          clr_err
);

   localparam int PAW   = $clog2(NSLC*DEPTH);
   localparam int WORDS = NSLC*DEPTH;

   logic [DW-1:0]  mem [WORDS];

   logic [DW-1:0]  rd_data_q,  rd_data_d;
   logic           rd_valid_q, rd_valid_d;
   logic           wr_ack_q,   wr_ack_d;
   logic [SW-1:0]  base_q,     base_d;
   logic           err_oob_q,  err_oob_d;

   logic           w_rd_oob;
   logic           w_wr_oob;
   logic           w_wr_go;
   logic [PAW-1:0] w_rd_pa;
   logic [PAW-1:0] w_wr_pa;
   logic [DW-1:0]  w_rd_mem;

   // slc and base are both below NSLC when in range, so one conditional
   // subtract implements the modulo.
   function automatic logic [PAW-1:0] phys_addr(input logic [SW-1:0] slc,
                                                input logic [SW-1:0] b,
                                                input logic [AW-1:0] addr);
      logic [SW:0] sum;
      logic [SW:0] p;
      sum = {1'b0, slc} + {1'b0, b};
      p   = (sum >= (SW+1)'(NSLC)) ? sum - (SW+1)'(NSLC) : sum;
      return PAW'(p) * PAW'(DEPTH) + PAW'(addr);
   endfunction

   always_comb begin
      w_rd_oob = ({1'b0, rd_addr} >= (AW+1)'(DEPTH)) || ({1'b0, rd_slc} >= (SW+1)'(NSLC));
      w_wr_oob = ({1'b0, wr_addr} >= (AW+1)'(DEPTH)) || ({1'b0, wr_slc} >= (SW+1)'(NSLC));
      w_rd_pa  = phys_addr(rd_slc, base_q, rd_addr);
      w_wr_pa  = phys_addr(wr_slc, base_q, wr_addr);
      w_wr_go  = wr_en && !w_wr_oob && rst_n;
      w_rd_mem = mem[w_rd_pa];
   end

   // RAM is not reset; writes during reset are suppressed via w_wr_go.
   always_ff @(posedge clk) begin
      if (w_wr_go) begin
         mem[w_wr_pa] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_en;
      wr_ack_d   = w_wr_go;
      base_d     = base_q;
      err_oob_d  = err_oob_q;

      if (rd_en) begin
         if (w_rd_oob) begin
            rd_data_d = '0;
         end else if (w_wr_go && (w_wr_pa == w_rd_pa)) begin
            rd_data_d = wr_data;
         end else begin
            rd_data_d = w_rd_mem;
         end
      end

      if (rotate) begin
         base_d = (base_q == SW'(NSLC-1)) ? '0 : base_q + 1'b1;
      end

      if ((rd_en && w_rd_oob) || (wr_en && w_wr_oob)) begin
         err_oob_d = 1'b1;
      end else if (clr_err) begin
         err_oob_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         wr_ack_q   <= 1'b0;
         base_q     <= '0;
         err_oob_q  <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         wr_ack_q   <= wr_ack_d;
         base_q     <= base_d;
         err_oob_q  <= err_oob_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign wr_ack   = wr_ack_q;
   assign base     = base_q;
   assign err_oob  = err_oob_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_slice_bank.sv
`default_nettype none
// ============================================================================
// tb_memory_slice_bank : directed stimulus checked against a behavioural model
// Revision : 1.0
// ============================================================================
module tb_memory_slice_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_en, wr_en, rotate, clr_err;
   logic [5:0]  rd_addr, wr_addr;
   logic [1:0]  rd_slc, wr_slc;
   logic [23:0] wr_data, rd_data;
   logic        rd_valid, wr_ack, err_oob;
   logic [1:0]  base;

   logic        s_rd_en, s_wr_en, s_rotate, s_clr_err;
   logic [6:0]  s_rd_addr, s_wr_addr;
   logic [1:0]  s_rd_slc, s_wr_slc;
   logic [31:0] s_wr_data, s_rd_data;
   logic        s_rd_valid, s_wr_ack, s_err_oob;
   logic [1:0]  s_base;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   memory_slice_bank dut (
      .clk(clk), .rst_n(rst_n),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_slc(rd_slc),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_slc(wr_slc), .wr_data(wr_data),
      .wr_ack(wr_ack), .rotate(rotate), .base(base),
      .err_oob(err_oob), .clr_err(clr_err)
   );

   memory_slice_bank #(.DW(32), .DEPTH(64), .NSLC(4), .AW(7), .SW(2)) dut_sw (
      .clk(clk), .rst_n(rst_n),
      .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_slc(s_rd_slc),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid),
      .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_slc(s_wr_slc), .wr_data(s_wr_data),
      .wr_ack(s_wr_ack), .rotate(s_rotate), .base(s_base),
      .err_oob(s_err_oob), .clr_err(s_clr_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: 3 slices x 40 words, mapping (slc+base)%3.
   logic [23:0] m_mem [120];
   bit          m_kn  [120];
   int          m_base   = 0;
   bit          m_err    = 0;
   bit          m_valid  = 0;
   bit          m_ack    = 0;
   logic [23:0] m_rdata  = '0;
   bit          m_rknown = 1;

   always @(posedge clk) begin : model
      int ra, wa;
      bit rb, wb, wgo;
      if (rst_n === 1'b1) begin
         rb  = (int'(rd_addr) >= 40) || (int'(rd_slc) >= 3);
         wb  = (int'(wr_addr) >= 40) || (int'(wr_slc) >= 3);
         ra  = ((int'(rd_slc) + m_base) % 3) * 40 + int'(rd_addr);
         wa  = ((int'(wr_slc) + m_base) % 3) * 40 + int'(wr_addr);
         wgo = wr_en && !wb;
         m_ack   = wgo;
         m_valid = rd_en;
         if (rd_en) begin
            if (rb) begin
               m_rdata = '0; m_rknown = 1;
            end else if (wgo && wa == ra) begin
               m_rdata = wr_data; m_rknown = 1;
            end else begin
               m_rdata = m_mem[ra]; m_rknown = m_kn[ra];
            end
         end
         if (wgo) begin
            m_mem[wa] = wr_data; m_kn[wa] = 1;
         end
         if ((rd_en && rb) || (wr_en && wb)) m_err = 1;
         else if (clr_err) m_err = 0;
         if (rotate) m_base = (m_base + 1) % 3;
      end
   end

   always @(negedge rst_n) begin
      m_base = 0; m_err = 0; m_valid = 0; m_ack = 0; m_rdata = '0; m_rknown = 1;
   end

   always @(posedge clk) begin
      #2;
      if (chk_en) begin
         chk("m_rd_valid", 64'(rd_valid), 64'(m_valid));
         chk("m_wr_ack",   64'(wr_ack),   64'(m_ack));
         chk("m_base",     64'(base),     64'(m_base));
         chk("m_err_oob",  64'(err_oob),  64'(m_err));
         if (m_rknown) chk("m_rd_data", 64'(rd_data), 64'(m_rdata));
      end
   end

   task automatic cyc(input logic re, input int rs, input int ra,
                      input logic we, input int ws, input int wa, input logic [23:0] wd,
                      input logic rot, input logic clr);
      @(negedge clk);
      rd_en = re; rd_slc = 2'(rs); rd_addr = 6'(ra);
      wr_en = we; wr_slc = 2'(ws); wr_addr = 6'(wa); wr_data = wd;
      rotate = rot; clr_err = clr;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 24'h0, 0, 0);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #3;
   endtask

   function automatic logic [31:0] sw_pat(input int s, input int a);
      return 32'hC300_0000 | 32'(s << 12) | 32'(a << 4) | 32'((s + a) & 15);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int ps;
      rst_n = 1'b0;
      rd_en = 0; rd_slc = 0; rd_addr = 0; wr_en = 0; wr_slc = 0; wr_addr = 0;
      wr_data = 0; rotate = 0; clr_err = 0;
      s_rd_en = 0; s_rd_slc = 0; s_rd_addr = 0; s_wr_en = 0; s_wr_slc = 0;
      s_wr_addr = 0; s_wr_data = 0; s_rotate = 0; s_clr_err = 0;
      repeat (3) @(posedge clk);
      #3;
      chk("reset_rd_valid", 64'(rd_valid), 64'(0));
      chk("reset_rd_data",  64'(rd_data),  64'(0));
      chk("reset_wr_ack",   64'(wr_ack),   64'(0));
      chk("reset_base",     64'(base),     64'(0));
      chk("reset_err_oob",  64'(err_oob),  64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1;

      // Basic write then read, slc 1 addr 5
      cyc(0, 0, 0, 1, 1, 5, 24'hABCDEF, 0, 0);
      after_edge();
      chk("wr_ack_pulse", 64'(wr_ack), 64'(1));
      cyc(1, 1, 5, 0, 0, 0, 24'h0, 0, 0);
      after_edge();
      chk("rd_valid_1cyc", 64'(rd_valid), 64'(1));
      chk("rd_data_abcdef", 64'(rd_data), 64'h00ABCDEF);
      chk("wr_ack_once", 64'(wr_ack), 64'(0));
      idle();
      after_edge();
      chk("rd_valid_drop", 64'(rd_valid), 64'(0));
      chk("rd_data_hold", 64'(rd_data), 64'h00ABCDEF);

      // Write-first forwarding
      cyc(1, 2, 39, 1, 2, 39, 24'h123456, 0, 0);
      after_edge();
      chk("fwd_data", 64'(rd_data), 64'h00123456);

      // Rotation
      cyc(0, 0, 0, 1, 0, 0, 24'h111111, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 24'h0, 1, 0);
      cyc(0, 0, 0, 0, 0, 0, 24'h0, 1, 0);
      after_edge();
      chk("base_two", 64'(base), 64'(2));
      cyc(1, 1, 0, 0, 0, 0, 24'h0, 1, 0);
      after_edge();
      chk("rot_read_prebase", 64'(rd_data), 64'h00111111);
      chk("base_wrap", 64'(base), 64'(0));

      // Out-of-range handling
      cyc(0, 0, 0, 1, 1, 0, 24'h222222, 0, 0);
      cyc(0, 0, 0, 1, 0, 40, 24'hBADBAD, 0, 0);
      after_edge();
      chk("oob_addr_ack", 64'(wr_ack), 64'(0));
      chk("oob_addr_err", 64'(err_oob), 64'(1));
      cyc(1, 1, 0, 0, 0, 0, 24'h0, 0, 0);
      after_edge();
      chk("oob_addr_ram", 64'(rd_data), 64'h00222222);
      cyc(0, 0, 0, 0, 0, 0, 24'h0, 0, 1);
      after_edge();
      chk("clr_err", 64'(err_oob), 64'(0));
      cyc(0, 0, 0, 1, 3, 0, 24'h333333, 0, 0);
      after_edge();
      chk("oob_slc_ack", 64'(wr_ack), 64'(0));
      chk("oob_slc_err", 64'(err_oob), 64'(1));
      cyc(1, 0, 0, 0, 0, 0, 24'h0, 0, 1);
      after_edge();
      chk("oob_slc_ram", 64'(rd_data), 64'h00111111);
      chk("clr_err2", 64'(err_oob), 64'(0));
      cyc(1, 3, 1, 0, 0, 0, 24'h0, 0, 1);
      after_edge();
      chk("set_wins", 64'(err_oob), 64'(1));
      chk("oob_rd_valid", 64'(rd_valid), 64'(1));
      chk("oob_rd_zero", 64'(rd_data), 64'(0));
      cyc(0, 0, 0, 0, 0, 0, 24'h0, 0, 1);

      // Back-to-back stream with periodic rotation
      for (int i = 0; i < 24; i++) begin
         int pws, pwa;
         pws = (i == 0) ? 0 : (i - 1) % 3;
         pwa = (i == 0) ? 0 : ((i - 1) * 7) % 40;
         cyc(i > 0, pws, pwa, 1, i % 3, (i * 7) % 40,
             24'(i * 24'h010101 + 24'h0F0F00), (i % 5) == 4, 0);
      end
      idle();

      // Asynchronous reset mid-stream
      if (m_base == 0) cyc(0, 0, 0, 0, 0, 0, 24'h0, 1, 0);
      cyc(0, 0, 0, 1, 2, 20, 24'h5A5A5A, 0, 0);
      ps = (2 + m_base) % 3;
      cyc(1, 2, 20, 0, 0, 0, 24'h0, 0, 0);
      after_edge();
      chk("pre_rst_valid", 64'(rd_valid), 64'(1));
      chk("pre_rst_base_nz", 64'(base != 0), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 64'(rd_valid), 64'(0));
      chk("async_rst_data", 64'(rd_data), 64'(0));
      chk("async_rst_base", 64'(base), 64'(0));
      cyc(0, 0, 0, 1, ps, 20, 24'hFFFFFF, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rd_en = 0; wr_en = 0;
      cyc(1, ps, 20, 0, 0, 0, 24'h0, 0, 0);
      after_edge();
      chk("post_rst_readback", 64'(rd_data), 64'h005A5A5A);
      idle();
      after_edge();
      chk_en = 0;

      // Parameter sweep instance
      for (int s = 0; s < 4; s++) begin
         for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            s_wr_en = 1; s_wr_slc = 2'(s); s_wr_addr = 7'(a); s_wr_data = sw_pat(s, a);
         end
      end
      @(negedge clk);
      s_wr_en = 0;
      for (int s = 0; s < 4; s++) begin
         for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            s_rd_en = 1; s_rd_slc = 2'(s); s_rd_addr = 7'(a);
            after_edge();
            chk("sweep_rd_data", 64'(s_rd_data), 64'(sw_pat(s, a)));
         end
      end
      @(negedge clk);
      s_rd_en = 0;
      chk("sweep_err_oob", 64'(s_err_oob), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
